// File: rtl/master_out_port_if.sv
// Serial master-to-slave link: bit lines and transaction qualifiers toward the slave, with slave_ready
// flowing back. The master modport drives the lines; the slave modport observes them and returns slave_ready.
interface master_out_port_if;
  logic tx_address;
  logic tx_data;
  logic master_valid;
  logic read_en;
  logic write_en;
  logic tx_burst;
  logic slave_ready;

  modport master (
    output tx_address,
    output tx_data,
    output master_valid,
    output read_en,
    output write_en,
    output tx_burst,
    input  slave_ready
  );

  modport slave (
    input  tx_address,
    input  tx_data,
    input  master_valid,
    input  read_en,
    input  write_en,
    input  tx_burst,
    output slave_ready
  );
endinterface

// File: rtl/master_out_port.sv
// Serialises one request LSB-first (address, then data beats); start->tx_done is 2+ADDR_WIDTH(+DATA_WIDTH per beat) cycles.
// slave_ready low freezes the current bit on its line; later burst beats are pulled in with data_ready/data_valid.
module master_out_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rd_wr,
  input  logic                  burst,
  input  logic [ADDR_WIDTH-1:0] address_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  busy,
  output logic                  tx_done,
  master_out_port_if.master     bus
);

  localparam int MAX_W  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W  = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int BEAT_W = $clog2(BURST_LEN + 1);

  localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [BEAT_W-1:0] BEATS     = BEAT_W'(BURST_LEN);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ADDR,
    DATA,
    WAIT_DATA,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr_sh;
  logic [DATA_WIDTH-1:0] data_sh;
  logic                  wr_q;
  logic                  burst_q;
  logic [CNT_W-1:0]      bit_cnt;
  logic [BEAT_W-1:0]     beat_cnt;
  logic [BEAT_W-1:0]     beat_nxt;

  logic load_req;
  logic shift_addr;
  logic shift_data;
  logic load_beat;
  logic inc_beat;
  logic clr_bit;
  logic active;
  logic tx_address_c;
  logic tx_data_c;

  assign beat_nxt = beat_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    load_req     = 1'b0;
    shift_addr   = 1'b0;
    shift_data   = 1'b0;
    load_beat    = 1'b0;
    inc_beat     = 1'b0;
    clr_bit      = 1'b0;
    active       = 1'b0;
    tx_address_c = 1'b0;
    tx_data_c    = 1'b0;
    data_ready   = 1'b0;
    tx_done      = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          load_req  = 1'b1;
          clr_bit   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        active = 1'b1;
        if (bus.slave_ready) begin
          clr_bit   = 1'b1;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        active       = 1'b1;
        tx_address_c = addr_sh[0];
        if (bus.slave_ready) begin
          shift_addr = 1'b1;
          if (bit_cnt == ADDR_LAST) begin
            clr_bit   = 1'b1;
            state_nxt = wr_q ? DATA : DONE;
          end
        end
      end
      DATA: begin
        active    = 1'b1;
        tx_data_c = data_sh[0];
        if (bus.slave_ready) begin
          shift_data = 1'b1;
          if (bit_cnt == DATA_LAST) begin
            clr_bit   = 1'b1;
            inc_beat  = 1'b1;
            state_nxt = (burst_q && (beat_nxt < BEATS)) ? WAIT_DATA : DONE;
          end
        end
      end
      WAIT_DATA: begin
        active     = 1'b1;
        data_ready = 1'b1;
        if (data_valid) begin
          load_beat = 1'b1;
          clr_bit   = 1'b1;
          state_nxt = DATA;
        end
      end
      DONE: begin
        tx_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Lines always present bit 0 of a shift register, so a stall simply holds it.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_sh  <= '0;
      data_sh  <= '0;
      wr_q     <= 1'b0;
      burst_q  <= 1'b0;
      bit_cnt  <= '0;
      beat_cnt <= '0;
    end else begin
      if (load_req) begin
        addr_sh  <= address_in;
        data_sh  <= data_in;
        wr_q     <= rd_wr;
        burst_q  <= burst;
        beat_cnt <= '0;
      end
      if (shift_addr) begin
        addr_sh <= addr_sh >> 1;
      end
      if (shift_data) begin
        data_sh <= data_sh >> 1;
      end
      if (load_beat) begin
        data_sh <= data_in;
      end
      if (inc_beat) begin
        beat_cnt <= beat_nxt;
      end
      if (clr_bit) begin
        bit_cnt <= '0;
      end else if (shift_addr || shift_data) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  assign busy             = (state != IDLE);
  assign bus.tx_address   = tx_address_c;
  assign bus.tx_data      = tx_data_c;
  assign bus.master_valid = active;
  assign bus.read_en      = active & ~wr_q;
  assign bus.write_en     = active & wr_q;
  assign bus.tx_burst     = active & burst_q;

endmodule

// File: tb/tb_master_out_port.sv
`timescale 1ns/1ps
// Random and directed transactions walked bit by bit from the protocol rules; every cycle's outputs
// are compared with the expected line values, plus start->tx_done latency and tx_done pulse counts.
module tb_master_out_port;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          rd_wr;
  logic          burst;
  logic [AW-1:0] address_in;
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic          data_ready;
  logic          busy;
  logic          tx_done;

  master_out_port_if bus ();

  master_out_port #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rd_wr      (rd_wr),
    .burst      (burst),
    .address_in (address_in),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .tx_done    (tx_done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cyc = -1000;
  int ndone    = 0;
  int start_cyc;

  logic [DW-1:0] beats [BL];
  int            wait_cfg [BL];
  bit            rand_sr;
  bit            noise;
  int            stall_bit;
  int            abort_bit;
  int            force_low;
  int            consec;
  logic          cur_wr;
  logic          cur_bst;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done === 1'b1) begin
      done_cyc = cyc;
      ndone++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] obs();
    return {bus.tx_address, bus.tx_data, bus.master_valid, bus.read_en, bus.write_en,
            bus.tx_burst, busy, tx_done, data_ready};
  endfunction

  // Expected output vector for a busy cycle of the current transaction.
  function automatic logic [8:0] ev(input logic ta, input logic td, input logic act,
                                    input logic done, input logic dr);
    return {ta, td, act, act & ~cur_wr, act & cur_wr, act & cur_bst, 1'b1, done, dr};
  endfunction

  task automatic pick_sr(output logic sr);
    if (force_low > 0) begin
      force_low--;
      sr = 1'b0;
    end else if (rand_sr) begin
      sr = (consec >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end else begin
      sr = 1'b1;
    end
    consec = sr ? 0 : consec + 1;
    bus.slave_ready = sr;
  endtask

  task automatic drive_noise();
    if (noise) begin
      start      = 1'($urandom);
      rd_wr      = 1'($urandom);
      burst      = 1'($urandom);
      address_in = AW'($urandom);
      data_in    = DW'($urandom);
      data_valid = 1'($urandom);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_txn(input logic wr, input logic bst, input logic [AW-1:0] a);
    int   nb;
    int   stalls;
    int   waits;
    int   d0;
    logic sr;
    logic dv;
    nb      = wr ? (bst ? BL : 1) : 0;
    stalls  = 0;
    waits   = 0;
    d0      = ndone;
    cur_wr  = wr;
    cur_bst = bst;
    consec  = 0;
    done_cyc = -1000;

    start      = 1'b1;
    rd_wr      = wr;
    burst      = bst;
    address_in = a;
    data_in    = beats[0];
    data_valid = 1'b0;
    #1 check("idle_pre", 32'(obs()), 32'h0);
    next_cycle();
    start     = 1'b0;
    start_cyc = cyc;

    do begin
      drive_noise();
      pick_sr(sr);
      #1 check("req", 32'(obs()), 32'(ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0)));
      if (!sr) stalls++;
      next_cycle();
    end while (!sr);

    for (int i = 0; i < AW; i++) begin
      if (i == stall_bit) force_low = 5;
      do begin
        drive_noise();
        pick_sr(sr);
        #1 check("addr_bit", 32'(obs()), 32'(ev(a[i], 1'b0, 1'b1, 1'b0, 1'b0)));
        if (!sr) stalls++;
        next_cycle();
      end while (!sr);
    end

    for (int b = 0; b < nb; b++) begin
      if (b > 0) begin
        int k;
        k = 0;
        do begin
          drive_noise();
          pick_sr(sr);
          dv         = (k >= wait_cfg[b]);
          data_valid = dv;
          data_in    = beats[b];
          #1 check("wait_data", 32'(obs()), 32'(ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b1)));
          waits++;
          k++;
          next_cycle();
        end while (!dv);
        data_valid = 1'b0;
      end
      for (int j = 0; j < DW; j++) begin
        if (b == 0 && j == abort_bit) begin
          #1 check("pre_abort_bit", 32'(obs()), 32'(ev(1'b0, beats[0][j], 1'b1, 1'b0, 1'b0)));
          reset = 1'b1;
          next_cycle();
          reset      = 1'b0;
          start      = 1'b0;
          data_valid = 1'b0;
          #1 check("abort_outputs", 32'(obs()), 32'h0);
          check("abort_no_done", 32'(ndone - d0), 32'h0);
          return;
        end
        do begin
          drive_noise();
          pick_sr(sr);
          #1 check("data_bit", 32'(obs()), 32'(ev(1'b0, beats[b][j], 1'b1, 1'b0, 1'b0)));
          if (!sr) stalls++;
          next_cycle();
        end while (!sr);
      end
    end

    drive_noise();
    pick_sr(sr);
    #1 check("done", 32'(obs()), 32'h006);
    next_cycle();
    start      = 1'b0;
    data_valid = 1'b0;
    #1 check("idle_post", 32'(obs()), 32'h0);
    check("latency", 32'(done_cyc - start_cyc + 1), 32'(2 + AW + DW * nb + waits + stalls));
    check("done_pulses", 32'(ndone - d0), 32'h1);
  endtask

  initial begin
    reset           = 1'b1;
    start           = 1'b0;
    rd_wr           = 1'b0;
    burst           = 1'b0;
    address_in      = '0;
    data_in         = '0;
    data_valid      = 1'b0;
    bus.slave_ready = 1'b0;
    rand_sr         = 1'b0;
    noise           = 1'b0;
    stall_bit       = -1;
    abort_bit       = -1;
    force_low       = 0;
    consec          = 0;
    cur_wr          = 1'b0;
    cur_bst         = 1'b0;
    for (int b = 0; b < BL; b++) begin
      beats[b]    = '0;
      wait_cfg[b] = 0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 check("reset_state", 32'(obs()), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Single write, fixed pattern; 22-cycle latency.
    beats[0] = 8'hBD;
    run_txn(1'b1, 1'b0, 12'hADD);
    check("single_write_latency", 32'(done_cyc - start_cyc + 1), 32'd22);

    // Read; 14-cycle latency, data line idle.
    run_txn(1'b0, 1'b0, 12'h5A3);
    check("read_latency", 32'(done_cyc - start_cyc + 1), 32'd14);

    // Burst write with beat 2 supplied late (data_ready high 3 cycles).
    beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33; beats[3] = 8'h44;
    wait_cfg[2] = 2;
    run_txn(1'b1, 1'b1, 12'h3C5);
    wait_cfg[2] = 0;

    // slave_ready low 5 cycles on address bit 5.
    beats[0]  = 8'h96;
    stall_bit = 5;
    run_txn(1'b1, 1'b0, 12'h7E1);
    check("stall_latency", 32'(done_cyc - start_cyc + 1), 32'd27);
    stall_bit = -1;

    // Reset during data bit 3, then a normal transfer.
    beats[0]  = 8'hA7;
    abort_bit = 3;
    run_txn(1'b1, 1'b0, 12'h123);
    abort_bit = -1;
    beats[0]  = 8'h5C;
    run_txn(1'b1, 1'b0, 12'h9F0);

    // Burst read: address phase only.
    run_txn(1'b0, 1'b1, 12'hB0B);

    // start and request inputs toggling while busy.
    noise    = 1'b1;
    beats[0] = 8'h3E;
    run_txn(1'b1, 1'b0, 12'h4D2);

    rand_sr = 1'b1;
    for (int t = 0; t < 40; t++) begin
      for (int b = 0; b < BL; b++) begin
        beats[b]    = DW'($urandom);
        wait_cfg[b] = $urandom_range(0, 3);
      end
      run_txn(1'($urandom), 1'($urandom), AW'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
